// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: HI/LO multiply, multiply-accumulate and iterative divide unit for the execute stage.
// Ports: clk/rst_n (async active-low); op_valid/op_ready issue handshake with op_code, src_a, src_b;
// flush cancels in-flight work; rd_sel/rd_data read HI (1) or LO (0); busy while a mult/div is in flight;
// hilo_valid when HI/LO hold final values.
module muldiv_hilo_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             hilo_valid
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DPRE = 2'd2, S_DITER = 2'd3;
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4,
                         OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MADD = 4'd7, OP_MADDU = 4'd8,
                         OP_MSUB = 4'd9, OP_MSUBU = 4'd10;
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi, r_lo, r_a, r_b, r_quo, r_rem, r_div;
  logic             r_qneg, r_rneg;
  logic             w_accept, w_is_mul, w_is_div, w_msgn, w_sdiv, w_ge, w_dz;
  logic [2*WIDTH-1:0] w_ma, w_mb, w_prod, w_hilo, w_mul_res;
  logic [WIDTH:0]   w_shift, w_diff;
  logic [WIDTH-1:0] w_rem_n, w_quo_n, w_q_fin, w_r_fin;
  assign busy       = r_state != S_IDLE;
  assign op_ready   = !busy;
  assign hilo_valid = !busy;
  assign rd_data    = rd_sel ? r_hi : r_lo;
  assign w_accept = op_valid && !busy && !flush;
  assign w_is_mul = op_code inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  assign w_is_div = op_code inside {OP_DIV, OP_DIVU};
  // Multiply on sign/zero-extended operands; the low 2*WIDTH bits are the correct product either way.
  assign w_msgn    = r_op inside {OP_MULT, OP_MADD, OP_MSUB};
  assign w_ma      = {{WIDTH{w_msgn & r_a[WIDTH-1]}}, r_a};
  assign w_mb      = {{WIDTH{w_msgn & r_b[WIDTH-1]}}, r_b};
  assign w_prod    = w_ma * w_mb;
  assign w_hilo    = {r_hi, r_lo};
  assign w_mul_res = (r_op inside {OP_MADD, OP_MADDU}) ? w_hilo + w_prod :
                     (r_op inside {OP_MSUB, OP_MSUBU}) ? w_hilo - w_prod : w_prod;
  // One restoring step: the dividend shifts out of r_quo into the partial remainder while quotient bits shift in.
  assign w_sdiv  = r_op == OP_DIV;
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_ge    = !w_diff[WIDTH];
  assign w_rem_n = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_n = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_fin = r_qneg ? -w_quo_n : w_quo_n;
  assign w_r_fin = r_rneg ? -w_rem_n : w_rem_n;
  assign w_dz    = r_b == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else if (busy && flush) begin
      r_state <= S_IDLE;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_a   <= src_a;
        r_b   <= src_b;
        r_op  <= op_code;
        r_cnt <= CW'(MUL_STAGES - 1);
        if (op_code == OP_MTHI) r_hi <= src_a;
        if (op_code == OP_MTLO) r_lo <= src_a;
        r_state <= w_is_mul ? S_MUL : w_is_div ? S_DPRE : S_IDLE;
      end
    end else if (r_state == S_MUL) begin
      if (r_cnt == '0) begin
        {r_hi, r_lo} <= w_mul_res;
        r_state      <= S_IDLE;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (r_state == S_DPRE) begin
      r_quo   <= (w_sdiv && r_a[WIDTH-1]) ? -r_a : r_a;
      r_div   <= (w_sdiv && r_b[WIDTH-1]) ? -r_b : r_b;
      r_rem   <= '0;
      r_qneg  <= w_sdiv && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
      r_rneg  <= w_sdiv && r_a[WIDTH-1];
      r_cnt   <= CW'(WIDTH - 1);
      r_state <= S_DITER;
    end else begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      if (r_cnt == '0) begin
        r_lo    <= w_dz ? '1 : w_q_fin;
        r_hi    <= w_dz ? r_a : w_r_fin;
        r_state <= S_IDLE;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule
